// File: rtl/adc_cmd_pio_ctrl.sv
// adc_cmd_pio_ctrl
//
// Avalon-MM slave PIO for ADC command/status. It has zero wait states and read latency 0.
// The command output supports direct, bit-set, bit-clear and retriggerable timed-pulse
// writes. The status input passes through a 2-flop synchroniser. When ADC_CMD_PIO_EDGE_IRQ_EN
// is defined, the input path also has edge capture (RW1C) and a maskable level interrupt.
// Without that macro, addresses 2/3 read 0, writes to them are ignored, and irq is tied to 0.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   address    register word address (0 DATA, 1 IN, 2 IRQMASK, 3 EDGE, 4 OUTSET,
//              5 OUTCLR, 6 PULSE, 7 reserved)
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data
//   readdata   combinational read data, zero-extended
//   in_port    asynchronous ADC status inputs
//   out_port   command outputs = data_out | pulse_bits
//   irq        level interrupt = |(edge_cap & irq_mask)

module adc_cmd_pio_ctrl #(
    parameter int unsigned OUT_WIDTH   = 4,
    parameter int unsigned IN_WIDTH    = 4,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int unsigned PULSE_LEN   = 8,
    parameter int unsigned EDGE_TYPE   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    input  logic [IN_WIDTH-1:0]  in_port,
    output logic [OUT_WIDTH-1:0] out_port,
    output logic                 irq
);

    localparam logic [2:0] AddrData   = 3'd0;
    localparam logic [2:0] AddrIn     = 3'd1;
    localparam logic [2:0] AddrMask   = 3'd2;
    localparam logic [2:0] AddrEdge   = 3'd3;
    localparam logic [2:0] AddrOutSet = 3'd4;
    localparam logic [2:0] AddrOutClr = 3'd5;
    localparam logic [2:0] AddrPulse  = 3'd6;

    localparam logic [15:0] PulseCnt = 16'(PULSE_LEN);

    typedef enum logic [0:0] {StIdle, StActive} pulse_state_e;

    logic                 wr;
    logic [OUT_WIDTH-1:0] wd_out;
    logic [IN_WIDTH-1:0]  wd_in;

    logic [OUT_WIDTH-1:0] data_q, data_d;
    logic [OUT_WIDTH-1:0] pulse_bits_q, pulse_bits_d;
    logic [15:0]          cnt_q, cnt_d;
    pulse_state_e         state_q, state_d;

    logic [IN_WIDTH-1:0]  sync1_q;
    logic [IN_WIDTH-1:0]  in_sync_q;

    // All writedata bits feed logic; the upper ones are intentionally don't-care.
    logic unused_wd;
    assign unused_wd = ^writedata;

    assign wr     = chipselect & ~write_n;
    assign wd_out = writedata[OUT_WIDTH-1:0];
    assign wd_in  = writedata[IN_WIDTH-1:0];

    // ------------------------------------------------------------------
    // Output data register
    // ------------------------------------------------------------------
    always_comb begin
        data_d = data_q;
        if (wr) begin
            case (address)
                AddrData:   data_d = wd_out;
                AddrOutSet: data_d = data_q | wd_out;
                AddrOutClr: data_d = data_q & ~wd_out;
                default:    data_d = data_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pulse FSM
    // ------------------------------------------------------------------
    always_comb begin
        pulse_bits_d = pulse_bits_q;
        cnt_d        = cnt_q;
        state_d      = state_q;

        unique case (state_q)
            StIdle: ;
            StActive: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end
                if (cnt_q <= 16'd1) begin
                    pulse_bits_d = '0;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A new nonzero pulse write takes priority over expiry. This keeps the pulse retriggerable.
        if (wr && (address == AddrPulse) && (wd_out != '0)) begin
            pulse_bits_d = pulse_bits_q | wd_out;
            cnt_d        = PulseCnt;
            state_d      = StActive;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q       <= RESET_VALUE[OUT_WIDTH-1:0];
            pulse_bits_q <= '0;
            cnt_q        <= '0;
            state_q      <= StIdle;
            sync1_q      <= '0;
            in_sync_q    <= '0;
        end else begin
            data_q       <= data_d;
            pulse_bits_q <= pulse_bits_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            sync1_q      <= in_port;
            in_sync_q    <= sync1_q;
        end
    end

    assign out_port = data_q | pulse_bits_q;

    // ------------------------------------------------------------------
    // Edge capture and interrupt
    // ------------------------------------------------------------------
`ifdef ADC_CMD_PIO_EDGE_IRQ_EN
    logic [IN_WIDTH-1:0] in_prev_q;
    logic [IN_WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [IN_WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [IN_WIDTH-1:0] edge_det;

    always_comb begin
        if (EDGE_TYPE == 0) begin
            edge_det = in_sync_q & ~in_prev_q;
        end else if (EDGE_TYPE == 1) begin
            edge_det = ~in_sync_q & in_prev_q;
        end else begin
            edge_det = in_sync_q ^ in_prev_q;
        end
    end

    always_comb begin
        irq_mask_d = irq_mask_q;
        edge_cap_d = edge_cap_q;
        if (wr && (address == AddrMask)) begin
            irq_mask_d = wd_in;
        end
        if (wr && (address == AddrEdge)) begin
            edge_cap_d = edge_cap_q & ~wd_in;
        end
        // A newly detected edge wins over a same-cycle clear.
        edge_cap_d = edge_cap_d | edge_det;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_prev_q  <= '0;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
        end else begin
            in_prev_q  <= in_sync_q;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
        end
    end

    assign irq = |(edge_cap_q & irq_mask_q);
`else
    assign irq = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        readdata = '0;
        case (address)
            AddrData:  readdata[OUT_WIDTH-1:0] = data_q;
            AddrIn:    readdata[IN_WIDTH-1:0]  = in_sync_q;
`ifdef ADC_CMD_PIO_EDGE_IRQ_EN
            AddrMask:  readdata[IN_WIDTH-1:0]  = irq_mask_q;
            AddrEdge:  readdata[IN_WIDTH-1:0]  = edge_cap_q;
`endif
            AddrPulse: readdata[OUT_WIDTH-1:0] = pulse_bits_q;
            default:   readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_adc_cmd_pio_ctrl.sv
module tb_adc_cmd_pio_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  in_port;
    logic [3:0]  out_port;
    logic        irq;

    int passed = 0;
    int total  = 0;

    adc_cmd_pio_ctrl #(
        .OUT_WIDTH  (4),
        .IN_WIDTH   (4),
        .RESET_VALUE(32'hA),
        .PULSE_LEN  (8),
        .EDGE_TYPE  (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .out_port  (out_port),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drives a one-cycle write. It returns just after the edge that commits the write.
    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(tag, readdata, exp);
    endtask

    initial begin
        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        #12;

        // Reset state
        chk("rst_out", {28'd0, out_port}, 32'hA);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rd_chk("rst_data", 3'd0, 32'hA);
        rd_chk("rst_in", 3'd1, 32'h0);
        rd_chk("rst_mask", 3'd2, 32'h0);
        rd_chk("rst_edge", 3'd3, 32'h0);
        rd_chk("rst_pulse", 3'd6, 32'h0);
        rd_chk("rst_rsvd", 3'd7, 32'h0);
        reset = 1'b0;
        tick();

        // Bit set / clear
        wr_reg(3'd0, 32'h0);
        chk("data0", {28'd0, out_port}, 32'h0);
        wr_reg(3'd4, 32'h5);
        chk("outset", {28'd0, out_port}, 32'h5);
        wr_reg(3'd5, 32'h1);
        chk("outclr", {28'd0, out_port}, 32'h4);
        rd_chk("rd_outset", 3'd4, 32'h0);
        rd_chk("rd_outclr", 3'd5, 32'h0);
        rd_chk("rd_data", 3'd0, 32'h4);

        // Reserved address ignores writes
        wr_reg(3'd7, 32'hF);
        chk("rsvd_wr", {28'd0, out_port}, 32'h4);

        // Zero pulse write is ignored
        wr_reg(3'd6, 32'h0);
        rd_chk("pulse_zero", 3'd6, 32'h0);
        chk("pulse_zero_out", {28'd0, out_port}, 32'h4);

        // Single pulse: high for exactly 8 cycles
        wr_reg(3'd6, 32'h2);
        rd_chk("pulse_rd", 3'd6, 32'h2);
        rd_chk("pulse_data_rd", 3'd0, 32'h4);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("pulse_hi_%0d", i), {28'd0, out_port}, 32'h6);
            tick();
        end
        chk("pulse_end", {28'd0, out_port}, 32'h4);
        rd_chk("pulse_end_rd", 3'd6, 32'h0);

        // Pulse overlapping a data bit keeps that bit high afterwards
        wr_reg(3'd6, 32'h4);
        repeat (8) tick();
        chk("pulse_overlap", {28'd0, out_port}, 32'h4);

        // Retrigger at cycle 5
        wr_reg(3'd0, 32'h0);
        wr_reg(3'd6, 32'h2);
        repeat (4) tick();
        chk("retrig_pre", {28'd0, out_port}, 32'h2);
        wr_reg(3'd6, 32'h4);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("retrig_hi_%0d", i), {28'd0, out_port}, 32'h6);
            tick();
        end
        chk("retrig_end", {28'd0, out_port}, 32'h0);

        // Mid-pulse reset
        wr_reg(3'd6, 32'h1);
        tick();
        tick();
        chk("mid_pulse", {28'd0, out_port}, 32'h1);
        reset = 1'b1;
        #1;
        chk("mid_rst_out", {28'd0, out_port}, 32'hA);
        rd_chk("mid_rst_pulse", 3'd6, 32'h0);
        reset = 1'b0;
        tick();

        // Input synchroniser
`ifdef ADC_CMD_PIO_EDGE_IRQ_EN
        wr_reg(3'd2, 32'h1);
        rd_chk("mask_rd", 3'd2, 32'h1);
`endif
        in_port = 4'h1;
        tick();
        rd_chk("in_1cyc", 3'd1, 32'h0);
        tick();
        rd_chk("in_2cyc", 3'd1, 32'h1);
        chk("irq_2cyc", {31'd0, irq}, 32'd0);
        tick();
`ifdef ADC_CMD_PIO_EDGE_IRQ_EN
        rd_chk("edge_3cyc", 3'd3, 32'h1);
        chk("irq_3cyc", {31'd0, irq}, 32'd1);
        wr_reg(3'd3, 32'h1);
        chk("irq_clr", {31'd0, irq}, 32'd0);
        rd_chk("edge_clr", 3'd3, 32'h0);
        // Edge arriving on the same edge as the clear must win
        in_port = 4'h0;
        repeat (4) tick();
        in_port = 4'h1;
        tick();
        tick();
        wr_reg(3'd3, 32'h1);
        rd_chk("edge_race", 3'd3, 32'h1);
        chk("irq_race", {31'd0, irq}, 32'd1);
`else
        // Without the feature, addresses 2/3 are inert and irq is tied to 0
        wr_reg(3'd2, 32'hF);
        wr_reg(3'd3, 32'hF);
        in_port = 4'h0;
        repeat (3) tick();
        in_port = 4'hF;
        repeat (4) tick();
        rd_chk("nomacro_mask", 3'd2, 32'h0);
        rd_chk("nomacro_edge", 3'd3, 32'h0);
        chk("nomacro_irq", {31'd0, irq}, 32'd0);
        rd_chk("nomacro_in", 3'd1, 32'hF);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/adc_cmd_pio_ctrl.md
# adc_cmd_pio_ctrl

Parametrised Avalon-MM slave PIO for ADC command/status on the NIOS II debug system. It drives a configurable-width command output with direct, bit-set, bit-clear and timed-pulse writes. It also samples a status input through a synchroniser with edge capture and a maskable interrupt. It sits on the NIOS II data master next to the other PIO slaves: zero wait states, read latency 0.

## Interface
- `OUT_WIDTH`, 4: width of `out_port`, 1..32.
- `IN_WIDTH`, 4: width of `in_port`, 1..32.
- `RESET_VALUE`, 0: reset value of the output data register.
- `PULSE_LEN`, 8: pulse duration in clk cycles, 1..65535.
- `EDGE_TYPE`, 0: edge to capture: 0 rising, 1 falling, 2 any.
- `clk` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `address` in 3: register word address.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data.
- `readdata` out 32: combinational read data; unused upper bits are 0.
- `in_port` in IN_WIDTH: asynchronous ADC status inputs.
- `out_port` out OUT_WIDTH: command outputs, equal to `data_out | pulse_bits`.
- `irq` out 1: level interrupt, equal to `|(edge_cap & irq_mask)`.

## Operation
- Write strobe `wr` = `chipselect & ~write_n`. Reads have no side effects.
- Register map:
  - 0 DATA, RW: writes `data_out <= writedata[OUT_WIDTH-1:0]`. Reads return `data_out` only, without pulse bits.
  - 1 IN, RO: synchronised input `in_sync`.
  - 2 IRQMASK, RW, IN_WIDTH bits.
  - 3 EDGE, RW1C: writing a 1 clears the corresponding captured bit.
  - 4 OUTSET, WO: `data_out <= data_out | wd`. Reads return 0.
  - 5 OUTCLR, WO: `data_out <= data_out & ~wd`. Reads return 0.
  - 6 PULSE, RW: writes `pulse_bits <= pulse_bits | wd` and load counter `cnt <= PULSE_LEN`. Reads return `pulse_bits`.
  - 7: reserved. Reads return 0; writes are ignored.
- Pulse FSM:
  - IDLE (`cnt==0`, `pulse_bits==0`) goes to ACTIVE on a PULSE write with nonzero data.
  - ACTIVE decrements `cnt` each cycle. When `cnt` goes from 1 to 0, `pulse_bits` clears and the FSM returns to IDLE.
  - A PULSE write during ACTIVE ORs in the new bits and restarts `cnt` at PULSE_LEN. The pulse is retriggerable.
  - A PULSE write of all zeros is ignored and does not reload the counter.
- Input path: 2-flop synchroniser gives `in_sync`. A third flop gives `in_prev`. Edge detect compares `in_sync` with `in_prev` per EDGE_TYPE and sets bits in `edge_cap`.
- Simultaneous events: on the same cycle and same bit, edge detect set beats an EDGE write-1-to-clear.
- Counter width: 16 bits, no wrap. `cnt` saturates at 0.

## Timing
- Reset values:
  - `data_out` = RESET_VALUE.
  - `pulse_bits`, `cnt`, `irq_mask`, `edge_cap`, and synchroniser flops = 0.
  - `out_port` = RESET_VALUE and `irq` = 0.
- Register writes update on the clk edge where `wr` is sampled. `out_port` and `irq` change in the following cycle.
- A pulse written at edge N puts `out_port` bits high from N+1 through N+PULSE_LEN inclusive, which is exactly PULSE_LEN cycles.
- A pulse bit that is also set in `data_out` stays high after the pulse ends.
- An `in_port` change is visible at IN 2 cycles after it is sampled. `edge_cap` sets on the 3rd edge, and `irq` rises in the same cycle.
- `reset` mid-pulse immediately clears `pulse_bits` and `cnt`. `out_port` returns to RESET_VALUE asynchronously.

## Configuration
- `ADC_CMD_PIO_EDGE_IRQ_EN` defined: the third flop, `edge_cap`, `irq_mask` and `irq` are built as described above.
- Macro undefined:
  - No edge or IRQ logic is built.
  - Addresses 2 and 3 read 0 and ignore writes.
  - `irq` is tied to 0.
  - The IN register and its 2-flop synchroniser remain.

## Test plan
- Reset with RESET_VALUE=4'hA: `out_port`=A, `irq`=0, and all readbacks are 0 except DATA, which reads A.
- Bit set/clear: write DATA=0, OUTSET=4'b0101, OUTCLR=4'b0001 -> `out_port`=4'b0100. OUTSET and OUTCLR read back 0.
- Pulse with PULSE_LEN=8: write PULSE=4'b0010 -> `out_port[1]` high for exactly 8 cycles, then `pulse_bits` reads 0.
- Pulse retrigger: rewrite PULSE at cycle 5 -> the pulse ends 8 cycles after the second write. A mid-pulse reset drops it at once.
- Rising edge with the macro defined: write IRQMASK=1 and drive `in_port[0]` 0->1.
  - IN reads 1 after 2 cycles.
  - EDGE=1 and `irq`=1 on the 3rd cycle.
  - Writing EDGE=1 clears `irq`.
  - An edge arriving in the same cycle as the clear keeps the bit set.
- Macro undefined: toggle `in_port` and write addr 2/3 -> `irq` stays 0 and addr 2/3 read 0.
